// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus sink: bus bit positions,
// command opcode masks, buffer geometry and the cursor step helper.
package lcd_pkg;

  localparam int EN_B = 10;
  localparam int RS_B = 9;
  localparam int RW_B = 8;

  localparam int LINE_LEN  = 16;
  localparam int NUM_CELLS = 32;
  localparam int IDX_W     = 5;

  // Each command is identified by its leading one; masks are tested in
  // priority order from the MSB down.
  localparam logic [7:0] CMD_DDRAM_M = 8'h80;
  localparam logic [7:0] CMD_CGRAM_M = 8'h40;
  localparam logic [7:0] CMD_FUNC_M  = 8'h20;
  localparam logic [7:0] CMD_SHIFT_M = 8'h10;
  localparam logic [7:0] CMD_DISP_M  = 8'h08;
  localparam logic [7:0] CMD_ENTRY_M = 8'h04;
  localparam logic [7:0] CMD_HOME_M  = 8'h02;
  localparam logic [7:0] CMD_CLEAR_M = 8'h01;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } sweep_state_t;

  // 5-bit wrap gives 15->16, 31->0 on increment and 0->31, 16->15 on
  // decrement, i.e. the two lines form one continuous ring.
  function automatic logic [IDX_W-1:0] idx_step(input logic [IDX_W-1:0] idx,
                                                input logic inc);
    return inc ? (idx + IDX_W'(1)) : (idx - IDX_W'(1));
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns old data.
module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic             Clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wa,
  input  logic [7:0]       wd,
  input  logic [IDX_W-1:0] ra,
  output logic [7:0]       rd
);

  logic [7:0] mem [NUM_CELLS];

  // Storage array; contents are initialised by the clear sweep, not by reset.
  always_ff @(posedge Clk) begin
    if (we) mem[wa] <= wd;
  end

  // Registered read, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!reset) rd <= 8'h00;
    else        rd <= mem[ra];
  end

endmodule

// File: rtl/lcd_bus_sink.sv
// Receiving end of the 11-bit character-LCD bus. Captures EN strobes,
// decodes HD44780-style commands/data into a 2x16 buffer and runs the
// clear sweep.
//
//  state   | meaning
//  S_IDLE  | accepting transfers
//  S_CLEAR | writing BLANK_CHAR to cell cnt, transfers rejected
module lcd_bus_sink
  import lcd_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR  = 8'h20,
  parameter int         EN_MIN_HIGH = 2
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [10:0]      lcd_bus,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_char,
  output logic [IDX_W-1:0] cursor_idx,
  output logic             disp_on,
  output logic             two_line,
  output logic             busy,
  output logic             wr_stb,
  output logic             err_stb
);

  localparam int RUN_W = $clog2(EN_MIN_HIGH + 1);
  localparam logic [IDX_W-1:0] LINE1_BASE = IDX_W'(LINE_LEN);
  localparam logic [IDX_W-1:0] LAST_CELL  = IDX_W'(NUM_CELLS - 1);

  logic [10:0]      bus_q, bus_qq;
  logic [RUN_W-1:0] run_cnt;
  logic [IDX_W-1:0] cursor_q, cursor_nxt;
  logic             id_q, id_nxt;
  logic             disp_q, disp_nxt;
  logic             two_q, two_nxt;
  logic             clr_pend;
  logic             wr_q, err_q;
  logic             fall, do_wr, do_err, start_clr;
  logic [7:0]       db;

  sweep_state_t     state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  logic             ram_we;
  logic [IDX_W-1:0] ram_wa;
  logic [7:0]       ram_wd;

  assign busy = (state == S_CLEAR);
  assign fall = bus_qq[EN_B] & ~bus_q[EN_B];
  assign db   = bus_qq[7:0];

  // Bus capture: bus_qq holds the last EN-high sample when the fall is seen.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      bus_q   <= '0;
      bus_qq  <= '0;
      run_cnt <= '0;
    end else begin
      bus_q  <= lcd_bus;
      bus_qq <= bus_q;
      if (!bus_q[EN_B])
        run_cnt <= '0;
      else if (run_cnt < RUN_W'(EN_MIN_HIGH))
        run_cnt <= run_cnt + RUN_W'(1);
    end
  end

  // Transfer decode on the commit cycle; produces next cursor/mode state.
  always_comb begin
    cursor_nxt = cursor_q;
    id_nxt     = id_q;
    disp_nxt   = disp_q;
    two_nxt    = two_q;
    do_wr      = 1'b0;
    do_err     = 1'b0;
    start_clr  = clr_pend;
    if (fall) begin
      if ((run_cnt < RUN_W'(EN_MIN_HIGH)) || busy || clr_pend || bus_qq[RW_B]) begin
        do_err = 1'b1;
      end else if (bus_qq[RS_B]) begin
        do_wr      = 1'b1;
        cursor_nxt = idx_step(cursor_q, id_q);
      end else if (|(db & CMD_DDRAM_M)) begin
        if (db[6:4] == 3'b000)      cursor_nxt = {1'b0, db[3:0]};
        else if (db[6:4] == 3'b100) cursor_nxt = LINE1_BASE | {1'b0, db[3:0]};
        else                        do_err = 1'b1;
      end else if (|(db & CMD_CGRAM_M)) begin
        do_err = 1'b1;
      end else if (|(db & CMD_FUNC_M)) begin
        two_nxt = db[3];
      end else if (|(db & CMD_SHIFT_M)) begin
        if (!db[3]) cursor_nxt = idx_step(cursor_q, db[2]);
      end else if (|(db & CMD_DISP_M)) begin
        disp_nxt = db[2];
      end else if (|(db & CMD_ENTRY_M)) begin
        id_nxt = db[1];
      end else if (|(db & CMD_HOME_M)) begin
        cursor_nxt = '0;
      end else if (|(db & CMD_CLEAR_M)) begin
        cursor_nxt = '0;
        id_nxt     = 1'b1;
        start_clr  = 1'b1;
      end
    end
  end

  // Cursor, mode bits and strobes.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      cursor_q <= '0;
      id_q     <= 1'b1;
      disp_q   <= 1'b0;
      two_q    <= 1'b0;
      clr_pend <= 1'b1;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cursor_q <= cursor_nxt;
      id_q     <= id_nxt;
      disp_q   <= disp_nxt;
      two_q    <= two_nxt;
      clr_pend <= 1'b0;
      wr_q     <= do_wr;
      err_q    <= do_err;
    end
  end

  // Sweep state register.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sweep next-state: one blank cell per cycle, 32 cycles in S_CLEAR.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start_clr) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        cnt_nxt = cnt + IDX_W'(1);
        if (cnt == LAST_CELL) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Buffer write mux; data writes are never accepted while sweeping.
  always_comb begin
    ram_we = do_wr | busy;
    ram_wa = busy ? cnt : cursor_q;
    ram_wd = busy ? BLANK_CHAR : db;
  end

  lcd_char_ram u_ram (
    .Clk   (Clk),
    .reset (reset),
    .we    (ram_we),
    .wa    (ram_wa),
    .wd    (ram_wd),
    .ra    (rd_idx),
    .rd    (rd_char)
  );

  assign cursor_idx = cursor_q;
  assign disp_on    = disp_q;
  assign two_line   = two_q;
  assign wr_stb     = wr_q;
  assign err_stb    = err_q;

endmodule
